// File: rtl/regfile_2r1w_pkg.sv
// Shared definitions for the 2-read/1-write integer register file.
// Holds the default geometry, the hard-wired zero register index and the
// register-index / register-word types used by decode and writeback.
package regfile_2r1w_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;

  // Index of the architectural register that always reads as zero.
  localparam int unsigned ZERO_REG_IDX = 0;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

endpackage : regfile_2r1w_pkg

// File: rtl/regfile_2r1w_read_port.sv
// Combinational read port with write-through bypass.
// Ports:
//   rst_n_i   - active-low reset; forces the read result to zero while low
//   addr_i    - register index to read
//   regs_i    - view of the current storage contents
//   wr_en_i   - write strobe of the write port (for bypass)
//   wr_addr_i - write destination index (for bypass)
//   wr_data_i - write data (for bypass)
//   data_o    - read data, zero-cycle latency
module regfile_read_port
  import regfile_2r1w_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_REGS   = 1 << ADDR_WIDTH
) (
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] regs_i [NUM_REGS],
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG_IDX);

  logic bypass_hit;

  // A write to the zero register never bypasses, so it cannot leak onto a read.
  assign bypass_hit = wr_en_i && (wr_addr_i != ZERO_ADDR) && (addr_i == wr_addr_i);

  // Reset and the zero register take priority over the bypass path.
  always_comb begin
    data_o = '0;
    if (!rst_n_i || (addr_i == ZERO_ADDR)) begin
      data_o = '0;
    end else if (bypass_hit) begin
      data_o = wr_data_i;
    end else begin
      data_o = regs_i[addr_i];
    end
  end

endmodule : regfile_read_port

// File: rtl/regfile_2r1w.sv
// Integer register file: 2 combinational read ports with write bypass,
// 1 synchronous write port, 1 registered debug read port. Register 0 is
// hard-wired to zero. Every entry resets asynchronously.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   wr_en/addr/data    - write port, applied on the rising edge
//   rs1_addr/rs1_data  - read port 1, combinational with bypass
//   rs2_addr/rs2_data  - read port 2, combinational with bypass
//   dbg_addr/dbg_data  - debug read, registered, no bypass
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int unsigned           NUM_REGS  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG_IDX);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] dbg_data_q;

  // Write decode; the zero entry is pinned so its flops collapse to constants.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != ZERO_ADDR)) begin
      regs_d[wr_addr] = wr_data;
    end
    regs_d[ZERO_ADDR] = '0;
  end

  // Flop-per-bit storage so every entry can be cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Debug read samples pre-write contents at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_data_q <= '0;
    end else begin
      dbg_data_q <= regs_q[dbg_addr];
    end
  end

  assign dbg_data = dbg_data_q;

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rs1_port (
    .rst_n_i   (rst_n),
    .addr_i    (rs1_addr),
    .regs_i    (regs_q),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .data_o    (rs1_data)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rs2_port (
    .rst_n_i   (rst_n),
    .addr_i    (rs2_addr),
    .regs_i    (regs_q),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .data_o    (rs2_data)
  );

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed scenarios followed by
// randomized traffic against an array-based reference model.
module tb_regfile_2r1w;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: architectural register contents.
  logic [31:0] mdl [32];

  regfile_2r1w #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rs1_addr (rs1_addr),
    .rs1_data (rs1_data),
    .rs2_addr (rs2_addr),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Expected read-port value from the architectural rules.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'h0;
    if (wr_en && wr_addr != 5'd0 && wr_addr == a) return wr_data;
    return mdl[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check read ports mid-cycle, advance model at the edge, check debug.
  task automatic tick(input string tag);
    logic [31:0] dbg_exp;
    @(negedge clk);
    check({tag, ".rs1"}, rs1_data, exp_rd(rs1_addr));
    check({tag, ".rs2"}, rs2_data, exp_rd(rs2_addr));
    @(posedge clk);
    if (rst_n) begin
      dbg_exp = mdl[dbg_addr];
      if (wr_en && wr_addr != 5'd0) mdl[wr_addr] = wr_data;
    end else begin
      dbg_exp = 32'h0;
    end
    #1;
    check({tag, ".dbg"}, dbg_data, dbg_exp);
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d, input string tag);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick(tag);
    wr_en = 1'b0;
  endtask

  // Asynchronous reset pulse placed away from the clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    check({tag, ".rs1_async"}, rs1_data, 32'h0);
    check({tag, ".rs2_async"}, rs2_data, 32'h0);
    check({tag, ".dbg_async"}, dbg_data, 32'h0);
    // Bypass condition and a write while in reset: both must be ignored.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D;
    rs1_addr = 5'd9; rs2_addr = 5'd9;
    tick({tag, ".in_reset"});
    wr_en = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;

    // Reset state, including a bypass attempt and a write under reset.
    #1;
    check("reset.dbg", dbg_data, 32'h0);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h11112222;
    rs1_addr = 5'd4; rs2_addr = 5'd4; dbg_addr = 5'd4;
    tick("reset.bypass");
    tick("reset.bypass2");
    wr_en = 1'b0;
    #3;
    rst_n = 1'b1;
    tick("reset.discard");
    check("reset.x4_clear", rs1_data, 32'h0);

    // Write then immediate async reset clears the entry with no clock edge.
    write(5'd5, 32'hDEADBEEF, "x5_wr");
    rs1_addr = 5'd5;
    #1;
    check("x5_before_rst", rs1_data, 32'hDEADBEEF);
    async_reset("rst_x5");
    rs1_addr = 5'd5;
    #1;
    check("x5_after_rst", rs1_data, 32'h0);

    // Write/read on both ports.
    write(5'd10, 32'h12345678, "x10_wr");
    rs1_addr = 5'd10; rs2_addr = 5'd10;
    #1;
    check("x10_rs1", rs1_data, 32'h12345678);
    check("x10_rs2", rs2_data, 32'h12345678);
    tick("x10_rd");

    // x0 guard.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    check("x0_same_cycle", rs1_data, 32'h0);
    tick("x0_wr");
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("x0_later", rs1_data, 32'h0);
      tick("x0_hold");
    end

    // Bypass on one port, plain read on the other, then both ports at once.
    write(5'd7, 32'h00000001, "x7_wr");
    write(5'd3, 32'h33333333, "x3_wr");
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    rs1_addr = 5'd7; rs2_addr = 5'd3;
    #1;
    check("bypass_rs1", rs1_data, 32'hA5A5A5A5);
    check("bypass_rs2_plain", rs2_data, 32'h33333333);
    tick("bypass");
    wr_addr = 5'd3; wr_data = 32'h5A5A5A5A; rs1_addr = 5'd3; rs2_addr = 5'd3;
    #1;
    check("bypass_both_rs1", rs1_data, 32'h5A5A5A5A);
    check("bypass_both_rs2", rs2_data, 32'h5A5A5A5A);
    tick("bypass_both");
    wr_en = 1'b0;

    // Debug port: old value after the write edge, new value one cycle later.
    write(5'd31, 32'h00000077, "x31_pre");
    dbg_addr = 5'd31;
    write(5'd31, 32'h00000055, "dbg_wr");
    check("dbg_old", dbg_data, 32'h00000077);
    tick("dbg_next");
    check("dbg_new", dbg_data, 32'h00000055);

    // Sweep: index+1 into x1..x31, then read all on both ports.
    for (int i = 1; i < 32; i++) write(5'(i), 32'(i + 1), "sweep_wr");
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i); dbg_addr = 5'(i);
      #1;
      check("sweep_rs1", rs1_data, (i == 0) ? 32'h0 : 32'(i + 1));
      check("sweep_rs2", rs2_data, (i == 31) ? 32'h0 : 32'(32 - i));
      tick("sweep_rd");
    end

    // Mid-operation reset wipes every entry.
    async_reset("rst_mid");
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i); dbg_addr = 5'(i);
      tick("post_rst");
    end

    // Randomized traffic, biased toward address collisions.
    for (int n = 0; n < 600; n++) begin
      wr_en   = 1'($urandom_range(0, 3) != 0);
      wr_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wr_data = $urandom;
      rs1_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      rs2_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      dbg_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      tick("rand");
      if (n % 150 == 149) async_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_2r1w
